// File: rtl/mpsoc_ahb3_spram_master.sv
// rtl/mpsoc_ahb3_spram_master.sv - AHB3-Lite master turning a valid/ready request stream into single NONSEQ transfers
// Optional misaligned-request rejection: define MPSOC_AHB3_SPRAM_MASTER_ALIGN_CHECK_EN.
module mpsoc_ahb3_spram_master #(
    parameter int         PLEN      = 64,
    parameter int         XLEN      = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic            HRESETn,
    input  logic            HCLK,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [PLEN-1:0] req_addr,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_wdata,

    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,

    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    // Address slot: BUSY drives NONSEQ, CANCEL holds a request parked by an ERROR,
    // BAD holds a rejected request that waits for the bus to drain.
    typedef enum logic [1:0] {
        AS_IDLE,
        AS_BUSY,
        AS_CANCEL,
        AS_BAD
    } aslot_t;

    aslot_t a_state, a_next;

    logic [XLEN-1:0] a_wdata;
    logic            d_valid;
    logic            d_write;

    logic req_bad;
    logic accept;
    logic addr_done;
    logic data_done;
    logic err_first;
    logic bad_retire;
    logic slot_free;

`ifdef MPSOC_AHB3_SPRAM_MASTER_ALIGN_CHECK_EN
    localparam int MAX_SIZE = $clog2(XLEN / 8);
    logic [PLEN-1:0] align_mask;

    always_comb begin
        align_mask = (PLEN'(1) << req_size) - PLEN'(1);
        req_bad    = (req_size > 3'(MAX_SIZE)) || ((req_addr & align_mask) != '0);
    end
`else
    assign req_bad = 1'b0;
`endif

    assign addr_done  = (a_state == AS_BUSY) && HREADY;
    assign data_done  = d_valid && HREADY;
    assign err_first  = d_valid && HRESP && !HREADY;
    assign bad_retire = (a_state == AS_BAD) && !d_valid;
    assign slot_free  = (a_state == AS_IDLE) || addr_done || bad_retire;
    assign accept     = req_valid && req_ready;

    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_state <= AS_IDLE;
        end else begin
            a_state <= a_next;
        end
    end

    always_comb begin
        a_next    = a_state;
        req_ready = slot_free && (a_state != AS_CANCEL);
        HTRANS    = (a_state == AS_BUSY) ? TRANS_NONSEQ : TRANS_IDLE;
        case (a_state)
            AS_BUSY: begin
                if (err_first) begin
                    a_next = AS_CANCEL;
                end else if (HREADY) begin
                    a_next = accept ? (req_bad ? AS_BAD : AS_BUSY) : AS_IDLE;
                end
            end
            AS_CANCEL: begin
                // Reissue once the erroring data phase has finished.
                if (data_done) begin
                    a_next = AS_BUSY;
                end
            end
            AS_BAD: begin
                if (!d_valid) begin
                    a_next = accept ? (req_bad ? AS_BAD : AS_BUSY) : AS_IDLE;
                end
            end
            default: begin
                if (accept) begin
                    a_next = req_bad ? AS_BAD : AS_BUSY;
                end
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HSIZE     <= 3'b000;
            a_wdata   <= '0;
            HWDATA    <= '0;
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                HADDR   <= req_addr;
                HWRITE  <= req_write;
                HSIZE   <= req_size;
                a_wdata <= req_wdata;
            end
            // Old a_wdata moves to HWDATA even if a new request lands on the same edge.
            if (addr_done) begin
                d_write <= HWRITE;
                if (HWRITE) begin
                    HWDATA <= a_wdata;
                end
            end
            d_valid   <= addr_done || (d_valid && !HREADY);
            rsp_valid <= data_done || bad_retire;
            if (data_done) begin
                rsp_err <= HRESP;
                if (!d_write) begin
                    rsp_rdata <= HRDATA;
                end
            end else if (bad_retire) begin
                rsp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mpsoc_ahb3_spram_master.sv
// tb/tb_mpsoc_ahb3_spram_master.sv - directed bench for mpsoc_ahb3_spram_master with a small AHB slave model
module tb_mpsoc_ahb3_spram_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    int errors = 0;
    int checks = 0;
    int rsp_cnt = 0;
    int ns_cnt = 0;
    int snap_rsp;
    int snap_ns;

    int          cfg_waits;
    logic        cfg_err_en;
    logic [63:0] cfg_err_addr;

    mpsoc_ahb3_spram_master #(
        .PLEN(64),
        .XLEN(32),
        .HPROT_VAL(4'b0011)
    ) dut (
        .HRESETn  (HRESETn),
        .HCLK     (HCLK),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_size (req_size),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .HADDR    (HADDR),
        .HWDATA   (HWDATA),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HBURST   (HBURST),
        .HPROT    (HPROT),
        .HTRANS   (HTRANS),
        .HMASTLOCK(HMASTLOCK),
        .HRDATA   (HRDATA),
        .HREADY   (HREADY),
        .HRESP    (HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Slave: unwritten words read as 0xA5000000 | byte address.
    logic [31:0] mem [256];
    logic        s_dp;
    logic        s_wr;
    logic        s_err;
    logic        s_stage;
    logic [7:0]  s_idx;
    int          s_wait;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_dp    <= 1'b0;
            s_wr    <= 1'b0;
            s_err   <= 1'b0;
            s_stage <= 1'b0;
            s_idx   <= 8'h00;
            s_wait  <= 0;
            for (int i = 0; i < 256; i++) begin
                mem[i] <= 32'hA500_0000 | 32'(i * 4);
            end
        end else if (HREADY) begin
            if (s_dp && s_wr && !s_err) begin
                mem[s_idx] <= HWDATA;
            end
            s_dp    <= (HTRANS == 2'b10);
            s_wr    <= HWRITE;
            s_idx   <= HADDR[9:2];
            s_wait  <= cfg_waits;
            s_err   <= cfg_err_en && (HADDR == cfg_err_addr);
            s_stage <= 1'b0;
        end else if (s_err) begin
            s_stage <= 1'b1;
        end else begin
            s_wait <= s_wait - 1;
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = 32'h0;
        if (s_dp) begin
            if (s_err) begin
                HRESP  = 1'b1;
                HREADY = s_stage;
            end else begin
                HREADY = (s_wait == 0);
            end
            if (!s_wr) begin
                HRDATA = mem[s_idx];
            end
        end
    end

    always @(negedge HCLK) begin
        if (rsp_valid) rsp_cnt++;
        if (HTRANS == 2'b10) ns_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    initial begin
        HRESETn      = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 64'h0;
        req_size     = 3'd2;
        req_wdata    = 32'h0;
        cfg_waits    = 0;
        cfg_err_en   = 1'b0;
        cfg_err_addr = 64'h0;

        // Reset state
        tick();
        tick();
        chk("rst_htrans", 64'(HTRANS), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("rst_haddr", HADDR, 64'h0);
        HRESETn = 1'b1;
        tick();
        chk("idle_htrans", 64'(HTRANS), 64'h0);
        chk("idle_req_ready", 64'(req_ready), 64'h1);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("idle_hburst", 64'(HBURST), 64'h0);
        chk("idle_hprot", 64'(HPROT), 64'h3);
        chk("idle_hmastlock", 64'(HMASTLOCK), 64'h0);

        // Back-to-back write then read @0x40, zero-wait slave
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h40;
        req_size  = 3'd2;
        req_wdata = 32'h1122_3344;
        tick();
        chk("wr_htrans", 64'(HTRANS), 64'h2);
        chk("wr_haddr", HADDR, 64'h40);
        chk("wr_hwrite", 64'(HWRITE), 64'h1);
        chk("wr_hsize", 64'(HSIZE), 64'h2);
        chk("wr_ready_overlap", 64'(req_ready), 64'h1);
        req_write = 1'b0;
        req_wdata = 32'h0;
        tick();
        chk("rd_htrans", 64'(HTRANS), 64'h2);
        chk("rd_hwrite", 64'(HWRITE), 64'h0);
        chk("wr_hwdata", 64'(HWDATA), 64'h1122_3344);
        req_valid = 1'b0;
        tick();
        chk("wr_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("wr_rsp_err", 64'(rsp_err), 64'h0);
        chk("b2b_htrans_idle", 64'(HTRANS), 64'h0);
        tick();
        chk("rd_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'h1122_3344);
        chk("rd_rsp_err", 64'(rsp_err), 64'h0);
        tick();
        chk("b2b_rsp_done", 64'(rsp_valid), 64'h0);

        // Read @0x8 with 3 wait states, followed by read @0xC
        cfg_waits = 3;
        req_valid = 1'b1;
        req_addr  = 64'h8;
        tick();
        req_addr = 64'hC;
        tick();
        cfg_waits = 0;
        chk("ws_ready_low", 64'(req_ready), 64'h0);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ws_htrans_hold", 64'(HTRANS), 64'h2);
            chk("ws_haddr_hold", HADDR, 64'hC);
            chk("ws_hwdata_hold", 64'(HWDATA), 64'h1122_3344);
            chk("ws_no_rsp", 64'(rsp_valid), 64'h0);
            tick();
        end
        chk("ws_last_wait_rsp", 64'(rsp_valid), 64'h0);
        tick();
        chk("ws_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("ws_rsp_rdata", 64'(rsp_rdata), 64'hA500_0008);
        tick();
        chk("ws_next_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("ws_next_rsp_rdata", 64'(rsp_rdata), 64'hA500_000C);
        tick();

        // ERROR on read @0x100 with read @0x104 pending
        cfg_err_en   = 1'b1;
        cfg_err_addr = 64'h100;
        req_valid    = 1'b1;
        req_addr     = 64'h100;
        tick();
        req_addr = 64'h104;
        tick();
        req_valid = 1'b0;
        chk("err1_hresp", 64'(HRESP), 64'h1);
        chk("err1_htrans", 64'(HTRANS), 64'h2);
        chk("err1_ready", 64'(req_ready), 64'h0);
        tick();
        chk("err2_htrans_cancel", 64'(HTRANS), 64'h0);
        chk("err2_haddr_kept", HADDR, 64'h104);
        chk("err2_ready", 64'(req_ready), 64'h0);
        chk("err2_no_rsp", 64'(rsp_valid), 64'h0);
        tick();
        chk("err_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("err_rsp_err", 64'(rsp_err), 64'h1);
        chk("err_reissue_htrans", 64'(HTRANS), 64'h2);
        chk("err_reissue_haddr", HADDR, 64'h104);
        tick();
        chk("err_gap_rsp", 64'(rsp_valid), 64'h0);
        tick();
        chk("reissue_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("reissue_rsp_err", 64'(rsp_err), 64'h0);
        chk("reissue_rsp_rdata", 64'(rsp_rdata), 64'hA500_0104);
        cfg_err_en = 1'b0;
        tick();
        tick();

        // Reset pulse with an address phase and a data phase pending
        cfg_waits = 2;
        req_valid = 1'b1;
        req_addr  = 64'h20;
        tick();
        req_addr = 64'h24;
        tick();
        chk("rp_pending_htrans", 64'(HTRANS), 64'h2);
        snap_rsp = rsp_cnt;
        HRESETn  = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rp_htrans", 64'(HTRANS), 64'h0);
        chk("rp_haddr", HADDR, 64'h0);
        chk("rp_hwdata", 64'(HWDATA), 64'h0);
        chk("rp_rsp_rdata", 64'(rsp_rdata), 64'h0);
        chk("rp_rsp_valid", 64'(rsp_valid), 64'h0);
        cfg_waits = 0;
        tick();
        HRESETn = 1'b1;
        snap_ns = ns_cnt;
        for (int i = 0; i < 5; i++) tick();
        chk("rp_no_rsp_after", 64'(rsp_cnt - snap_rsp), 64'h0);
        chk("rp_no_nonseq_after", 64'(ns_cnt - snap_ns), 64'h0);
        chk("rp_ready_after", 64'(req_ready), 64'h1);

`ifdef MPSOC_AHB3_SPRAM_MASTER_ALIGN_CHECK_EN
        // Misaligned word read @0x2 behind a good read @0x0
        snap_ns   = ns_cnt;
        req_valid = 1'b1;
        req_addr  = 64'h0;
        req_size  = 3'd2;
        tick();
        req_addr = 64'h2;
        tick();
        req_valid = 1'b0;
        chk("al_htrans_idle", 64'(HTRANS), 64'h0);
        tick();
        chk("al_good_rsp", 64'(rsp_valid), 64'h1);
        chk("al_good_err", 64'(rsp_err), 64'h0);
        tick();
        chk("al_bad_rsp", 64'(rsp_valid), 64'h1);
        chk("al_bad_err", 64'(rsp_err), 64'h1);
        chk("al_nonseq_count", 64'(ns_cnt - snap_ns), 64'h1);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mpsoc_ahb3_spram_master.md
Name: mpsoc_ahb3_spram_master

Overview:
- AHB3-Lite master engine that turns a simple valid/ready request stream into single NONSEQ AHB transfers and returns in-order responses.
- Drives the spram AHB slave, and any AHB3-Lite slave, from test engines, DMA front-ends and memory-init logic.
- Overlaps the address phase of transfer N+1 with the data phase of transfer N.
- Absorbs wait states and two-cycle ERROR responses.

Parameters:
- PLEN, 64, address width (HADDR, req_addr).
- XLEN, 32, data width (HWDATA, HRDATA, req_wdata, rsp_rdata); power of two, 8..1024.
- HPROT_VAL, 4'b0011, constant driven on HPROT (data, privileged, non-bufferable).

Ports:
- HRESETn  in  1  asynchronous active-low reset.
- HCLK  in  1  clock; all logic rising-edge.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a rising edge.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  PLEN  byte address.
- req_size  in  3  HSIZE encoding.
- req_wdata  in  XLEN  write data, already lane-aligned to req_addr.
- rsp_valid  out  1  one-cycle pulse; one per accepted request, in order.
- rsp_rdata  out  XLEN  read data; holds the last captured value.
- rsp_err  out  1  qualified by rsp_valid; 1 = slave returned ERROR.
- HADDR  out  PLEN  AHB address.
- HWDATA  out  XLEN  AHB write data.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  AHB size.
- HBURST  out  3  AHB burst; always SINGLE (3'b000).
- HPROT  out  4  equals HPROT_VAL.
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- HMASTLOCK  out  1  always 0.
- HRDATA  in  XLEN  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  1  AHB response; 0 = OKAY, 1 = ERROR.

Behaviour:
- Reset (async, immediate) values:
  - HTRANS=IDLE; HADDR, HWDATA, HWRITE, HSIZE = 0.
  - HBURST=0, HPROT=HPROT_VAL, HMASTLOCK=0.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - Address and data slots empty.
  - Reset mid-transfer drops all pending requests; no responses are issued for them.
- Address slot (registered HADDR/HWRITE/HSIZE/HTRANS):
  - Free when HTRANS==IDLE, or when HTRANS==NONSEQ and HREADY==1 (completing this edge).
  - req_ready = address slot free AND no error-cancel in progress. Combinational from state and HREADY only, never from req_valid.
  - On acceptance, the next cycle drives HTRANS=NONSEQ with the request's address, write flag and size.
  - With no acceptance while the slot frees, HTRANS returns to IDLE.
  - HADDR/HWRITE/HSIZE hold while HREADY==0.
- Data slot:
  - Loaded when an address phase completes (NONSEQ & HREADY at an edge).
  - For writes, HWDATA is registered at that edge and held until the data phase completes.
  - Data phase completes at an edge with HREADY==1. That edge:
    - sets rsp_valid=1 for exactly one cycle;
    - sets rsp_err=HRESP;
    - for reads, sets rsp_rdata=HRDATA.
  - Writes leave rsp_rdata unchanged.
- Throughput: back-to-back requests with a zero-wait slave give one response per cycle. Latency from acceptance to rsp_valid is 2 cycles with a zero-wait slave, plus one cycle per wait state.
- ERROR handling:
  - Trigger: HRESP==1 & HREADY==0 during a data phase.
  - If the address slot holds a NONSEQ, the next cycle drives HTRANS=IDLE (cancel), keeping HADDR/HWRITE/HSIZE.
  - After the second error cycle (HREADY==1, rsp_valid with rsp_err=1), the cancelled transfer is re-driven as NONSEQ.
  - The cancelled request is reissued, not dropped; response order is preserved.
  - req_ready=0 during the cancel cycle.
- Simultaneous events: acceptance and address-phase completion on the same edge replace the slot contents. No request is lost or duplicated.

Optional Feature:
- Macro: MPSOC_AHB3_SPRAM_MASTER_ALIGN_CHECK_EN.
- Defined:
  - A request whose req_addr is not aligned to 2^req_size bytes, or whose req_size exceeds log2(XLEN/8), is accepted but never put on the bus.
  - It waits until both slots are empty, then produces rsp_valid with rsp_err=1. Order is preserved; HTRANS stays IDLE for it.
- Undefined: all requests are forwarded to the bus unchecked.

Test Plan:
- Reset release, no requests -> HTRANS=IDLE, req_ready=1, rsp_valid=0; HBURST=0, HPROT=4'b0011, HMASTLOCK=0 constant.
- Zero-wait slave, write 0x11223344 @0x40 (size 2), then read @0x40 back-to-back -> NONSEQ on consecutive cycles; HWDATA=0x11223344 in the write data phase; two rsp_valid pulses on consecutive cycles; the read gives rsp_rdata=0x11223344, rsp_err=0.
- Slave inserts 3 wait states on a read @0x8 -> HADDR/HWDATA/next NONSEQ held stable; rsp_valid exactly 5 cycles after acceptance.
- ERROR on read @0x100 with a pending read @0x104 -> HTRANS=IDLE in error cycle 2; rsp_err=1 for 0x100; 0x104 re-issued as NONSEQ; rsp_err=0 for 0x104.
- HRESETn pulsed low while a NONSEQ and a data phase are pending -> outputs reach reset values immediately; no rsp_valid after release.
- With MPSOC_AHB3_SPRAM_MASTER_ALIGN_CHECK_EN, word read @0x2 -> no NONSEQ driven; rsp_valid with rsp_err=1 after earlier responses drain.
